// File: rtl/pix_scan_seq.sv
// pix_scan_seq: register-bus programmed readout sequencer for the pixel matrix.
// Ports: BUS_* 8-bit register bus; ROW_RESET/CLK_ROW/CLK_COL/ROW_SAMPLE1/
// ROW_SAMPLE2/RESET_ROW_CNT/RESET_COL_CNT/ADC_SYNC strobes; BUSY status.
// Build option: define PIX_SCAN_SAMPLE2_EN to include the SMP2 state.
module pix_scan_seq #(
  parameter logic [15:0] BASEADDR = 16'h0000,
  parameter logic [15:0] HIGHADDR = 16'h0000,
  parameter int unsigned ROWS     = 64,
  parameter int unsigned COLS     = 64
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST_B,
  input  logic [15:0] BUS_ADD,
  inout  wire  [7:0]  BUS_DATA,
  input  logic        BUS_RD,
  input  logic        BUS_WR,
  output logic        ROW_RESET,
  output logic        CLK_ROW,
  output logic        CLK_COL,
  output logic        ROW_SAMPLE1,
  output logic        ROW_SAMPLE2,
  output logic        RESET_ROW_CNT,
  output logic        RESET_COL_CNT,
  output logic        ADC_SYNC,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_RST, S_SMP1, S_COL, S_SMP2, S_ADV
  } state_t;

  localparam logic [15:0] SPAN     = HIGHADDR - BASEADDR;
  localparam logic [15:0] ROW_LAST = 16'(ROWS - 1);
  localparam logic [15:0] COL_LAST = 16'(COLS - 1);

  logic [16:0] diff;
  logic        in_rng;
  logic [2:0]  off;
  logic        wr_hit, soft_rst, start, stop, rst;

  // Borrow bit of the 17-bit difference flags addresses below BASEADDR.
  assign diff     = {1'b0, BUS_ADD} - {1'b0, BASEADDR};
  assign in_rng   = !diff[16] && (diff[15:0] <= SPAN);
  assign off      = diff[2:0];
  assign wr_hit   = BUS_WR && in_rng;
  assign soft_rst = wr_hit && (off == 3'd0);
  assign start    = wr_hit && (off == 3'd1);
  assign stop     = wr_hit && (off == 3'd6);
  assign rst      = !BUS_RST_B || soft_rst;

  logic [7:0] len_q, half_q, rep_q;
  logic [7:0] len_l_q, half_l_q, rep_l_q;

  always_ff @(posedge BUS_CLK) begin
    if (rst) begin
      len_q  <= 8'd4;
      half_q <= 8'd1;
      rep_q  <= 8'd1;
    end else if (wr_hit) begin
      if (off == 3'd3) len_q  <= BUS_DATA;
      if (off == 3'd4) half_q <= BUS_DATA;
      if (off == 3'd5) rep_q  <= BUS_DATA;
    end
  end

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] col_q, col_d;
  logic [15:0] row_q, row_d;
  logic        ph_q, ph_d;
  logic [7:0]  frame_q, frame_d;
  logic        done_q, done_d;
  logic        init_entry;

  assign init_entry = (state_d == S_INIT) && (state_q != S_INIT);

  always_ff @(posedge BUS_CLK) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      ph_q     <= 1'b0;
      frame_q  <= '0;
      done_q   <= 1'b0;
      len_l_q  <= 8'd1;
      half_l_q <= 8'd1;
      rep_l_q  <= 8'd1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ph_q    <= ph_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      // Timing config is frozen per frame; zero lengths act as one.
      if (init_entry) begin
        len_l_q  <= (len_q == 8'd0) ? 8'd1 : len_q;
        half_l_q <= (half_q == 8'd0) ? 8'd1 : half_q;
        rep_l_q  <= rep_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    ph_d    = ph_q;
    frame_d = frame_q;
    done_d  = done_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_INIT;
        cnt_d   = '0;
        frame_d = '0;
        done_d  = 1'b0;
      end
      S_INIT: begin
        row_d = '0;
        if (cnt_q == 8'd1) begin
          state_d = S_RST;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_RST: begin
        if (cnt_q == len_l_q - 8'd1) begin
          state_d = S_SMP1;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_SMP1: begin
        state_d = S_COL;
        cnt_d   = '0;
        col_d   = '0;
        ph_d    = 1'b1;
      end
      S_COL: begin
        if (cnt_q == half_l_q - 8'd1) begin
          cnt_d = '0;
          if (ph_q) ph_d = 1'b0;
          else if (col_q == COL_LAST) begin
`ifdef PIX_SCAN_SAMPLE2_EN
            state_d = S_SMP2;
`else
            state_d = S_ADV;
`endif
          end else begin
            col_d = col_q + 16'd1;
            ph_d  = 1'b1;
          end
        end else cnt_d = cnt_q + 8'd1;
      end
      S_SMP2: begin
        state_d = S_ADV;
        cnt_d   = '0;
      end
      S_ADV: begin
        if (cnt_q == 8'd0) cnt_d = 8'd1;
        else begin
          cnt_d = '0;
          if (row_q != ROW_LAST) begin
            row_d   = row_q + 16'd1;
            state_d = S_RST;
          end else begin
            frame_d = frame_q + 8'd1;
            if ((rep_l_q != 8'd0) && (frame_d == rep_l_q)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else state_d = S_INIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (stop) state_d = S_IDLE;
  end

  // Strobes are decoded from next state so every output is a flop.
  logic rr_d, cr_d, cc_d, s1_d, s2_d, rc_d, adc_d, busy_d;

  always_comb begin
    rr_d   = (state_d == S_RST);
    rc_d   = (state_d == S_INIT);
    s1_d   = (state_d == S_SMP1);
    cc_d   = (state_d == S_COL) && ph_d;
    adc_d  = (state_d == S_COL) && (state_q != S_COL);
    cr_d   = (state_d == S_ADV) && (cnt_d == 8'd0);
    busy_d = (state_d != S_IDLE);
`ifdef PIX_SCAN_SAMPLE2_EN
    s2_d   = (state_d == S_SMP2);
`else
    s2_d   = 1'b0;
`endif
  end

  always_ff @(posedge BUS_CLK) begin
    if (rst) begin
      ROW_RESET     <= 1'b0;
      CLK_ROW       <= 1'b0;
      CLK_COL       <= 1'b0;
      ROW_SAMPLE1   <= 1'b0;
      ROW_SAMPLE2   <= 1'b0;
      RESET_ROW_CNT <= 1'b0;
      RESET_COL_CNT <= 1'b0;
      ADC_SYNC      <= 1'b0;
      BUSY          <= 1'b0;
    end else begin
      ROW_RESET     <= rr_d;
      CLK_ROW       <= cr_d;
      CLK_COL       <= cc_d;
      ROW_SAMPLE1   <= s1_d;
      ROW_SAMPLE2   <= s2_d;
      RESET_ROW_CNT <= rc_d;
      RESET_COL_CNT <= rc_d;
      ADC_SYNC      <= adc_d;
      BUSY          <= busy_d;
    end
  end

  logic [7:0] rd_mux, rd_data_q;
  logic       rd_vld_q;

  always_comb begin
    rd_mux = '0;
    unique case (off)
      3'd0: rd_mux = 8'd1;
      3'd2: rd_mux = {6'd0, BUSY, done_q};
      3'd3: rd_mux = len_q;
      3'd4: rd_mux = half_q;
      3'd5: rd_mux = rep_q;
      3'd7: rd_mux = frame_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_vld_q <= BUS_RD && in_rng;
      if (BUS_RD && in_rng) rd_data_q <= rd_mux;
    end
  end

  assign BUS_DATA = rd_vld_q ? rd_data_q : 8'bz;

endmodule

// File: tb/tb_pix_scan_seq.sv
// tb_pix_scan_seq: directed + randomized bench for pix_scan_seq.
// Expected waveforms are expanded from the per-state timing rules.
module tb_pix_scan_seq;

  localparam int ROWS = 4;
  localparam int COLS = 8;
  localparam logic [15:0] BASE = 16'h0100;
`ifdef PIX_SCAN_SAMPLE2_EN
  localparam int S = 1;
`else
  localparam int S = 0;
`endif

  localparam int B_RR = 0, B_CR = 1, B_CC = 2, B_S1 = 3, B_S2 = 4;
  localparam int B_RRC = 5, B_RCC = 6, B_ADC = 7, B_BUSY = 8;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic [15:0] add = BASE;
  logic [7:0] dout = '0;
  logic drv = 1'b0, rd = 1'b0, wr = 1'b0;
  wire  [7:0] BUS_DATA;
  logic rr, cr, cc, s1, s2, rrc, rcc, adc, busy;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  assign BUS_DATA = drv ? dout : 8'bz;

  always #5 clk = ~clk;

  pix_scan_seq #(
    .BASEADDR(BASE), .HIGHADDR(BASE + 16'd7), .ROWS(ROWS), .COLS(COLS)
  ) dut (
    .BUS_CLK(clk), .BUS_RST_B(rst_b), .BUS_ADD(add), .BUS_DATA(BUS_DATA),
    .BUS_RD(rd), .BUS_WR(wr), .ROW_RESET(rr), .CLK_ROW(cr), .CLK_COL(cc),
    .ROW_SAMPLE1(s1), .ROW_SAMPLE2(s2), .RESET_ROW_CNT(rrc),
    .RESET_COL_CNT(rcc), .ADC_SYNC(adc), .BUSY(busy)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] obs();
    return {busy, adc, rcc, rrc, s2, s1, cc, cr, rr};
  endfunction

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int row_len(input int l, input int h);
    return eff(l) + 1 + 2 * eff(h) * COLS + S + 2;
  endfunction

  task automatic push(input int bits);
    exp_q.push_back(9'(bits) | 9'(1 << B_BUSY));
  endtask

  task automatic push_frame(input int l, input int h);
    repeat (2) push((1 << B_RRC) | (1 << B_RCC));
    for (int r = 0; r < ROWS; r++) begin
      repeat (l) push(1 << B_RR);
      push(1 << B_S1);
      for (int c = 0; c < COLS; c++) begin
        for (int k = 0; k < h; k++)
          push((1 << B_CC) | ((c == 0 && k == 0) ? (1 << B_ADC) : 0));
        for (int k = 0; k < h; k++) push(0);
      end
      if (S == 1) push(1 << B_S2);
      push(1 << B_CR);
      push(0);
    end
  endtask

  task automatic bus_wr(input logic [2:0] o, input logic [7:0] d);
    @(negedge clk);
    add = BASE + 16'(o); dout = d; drv = 1'b1; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0; drv = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] o, output logic [7:0] d);
    @(negedge clk);
    add = BASE + 16'(o); rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    d = BUS_DATA;
  endtask

  task automatic chk_rd(input string tag, input logic [2:0] o,
                        input logic [7:0] e);
    logic [7:0] d;
    bus_rd(o, d);
    checks++;
    assert (d === e) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, d, e);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int e);
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, e);
    end
  endtask

  // START, then compare every cycle against the expanded model. A bus
  // write can be injected at cycle inj_at (-1: first CLK_COL-high cycle
  // from 20 on); kill means that write ends the scan at once.
  task automatic run(input string tag, input int nfr, input int l,
                     input int h, input int l2, input int inj_at,
                     input logic [2:0] io, input logic [7:0] idat,
                     input bit kill, output int busy_n);
    int at, bad, fi;
    logic [8:0] v, fv, fe;
    exp_q.delete();
    for (int f = 0; f < nfr; f++)
      push_frame(eff(f == 0 ? l : l2), eff(h));
    repeat (2) exp_q.push_back('0);
    at = inj_at;
    if (at < 0) begin
      at = 20;
      while (at < exp_q.size() && !exp_q[at][B_CC]) at++;
    end
    if (kill) begin
      while (exp_q.size() > at + 1) void'(exp_q.pop_back());
      repeat (3) exp_q.push_back('0);
    end
    bus_wr(3'd1, 8'h00);
    busy_n = 0; bad = 0; fi = -1; fv = '0; fe = '0;
    for (int i = 0; i < exp_q.size(); i++) begin
      v = obs();
      busy_n += int'(v[B_BUSY]);
      if (v !== exp_q[i]) begin
        if (bad == 0) begin fi = i; fv = v; fe = exp_q[i]; end
        bad++;
      end
      if (i == at) begin
        add = BASE + 16'(io); dout = idat; drv = 1'b1; wr = 1'b1;
      end
      @(negedge clk);
      wr = 1'b0; drv = 1'b0;
    end
    checks++;
    assert (bad === 0) else begin
      errors++;
      $error("FAIL %s wave: %0d bad cycles, first at %0d got %b expected %b",
             tag, bad, fi, fv, fe);
    end
  endtask

  initial begin
    int bn, l, h, rp, l2, frame;
    logic [7:0] d;

    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    checks++;
    assert (obs() === 9'd0) else begin
      errors++;
      $error("FAIL reset_outs: got %b expected %b", obs(), 9'd0);
    end
    checks++;
    assert (BUS_DATA === 8'hzz) else begin
      errors++;
      $error("FAIL reset_bus_z: got %h expected zz", BUS_DATA);
    end
    chk_rd("version", 3'd0, 8'h01);
    @(negedge clk);
    checks++;
    assert (BUS_DATA === 8'hzz) else begin
      errors++;
      $error("FAIL read_release_z: got %h expected zz", BUS_DATA);
    end
    chk_rd("rst_len", 3'd3, 8'd4);
    chk_rd("rst_half", 3'd4, 8'd1);
    chk_rd("rst_rep", 3'd5, 8'd1);
    chk_rd("rst_status", 3'd2, 8'd0);

    run("default", 1, 4, 1, 4, 32'h7fffffff, 3'd0, 8'd0, 1'b0, bn);
    chk_rd("default_status", 3'd2, 8'h01);

    bus_wr(3'd3, 8'd3); bus_wr(3'd4, 8'd2); bus_wr(3'd5, 8'd1);
    run("single", 1, 3, 2, 3, 32'h7fffffff, 3'd0, 8'd0, 1'b0, bn);
    chk_int("single_busy", bn, (S == 1) ? 158 : 154);
    chk_rd("single_status", 3'd2, 8'h01);
    chk_rd("single_frames", 3'd7, 8'd1);

    bus_wr(3'd5, 8'd3);
    run("multi", 3, 3, 2, 3, 50, 3'd1, 8'd0, 1'b0, bn);
    chk_int("multi_busy", bn, (S == 1) ? 474 : 462);
    chk_rd("multi_frames", 3'd7, 8'd3);

    for (int k = 0; k < 4; k++) begin
      l  = int'($urandom_range(0, 5));
      h  = int'($urandom_range(0, 3));
      rp = int'($urandom_range(1, 2));
      l2 = int'($urandom_range(0, 5));
      bus_wr(3'd3, 8'(l)); bus_wr(3'd4, 8'(h)); bus_wr(3'd5, 8'(rp));
      run("rand", rp, l, h, l2, 10, 3'd3, 8'(l2), 1'b0, bn);
      chk_int("rand_busy", bn,
              2 * rp + ROWS * (row_len(l, h) + (rp - 1) * 0) +
              (rp - 1) * ROWS * row_len(l2, h));
      chk_rd("rand_frames", 3'd7, 8'(rp));
    end

    bus_wr(3'd3, 8'd3); bus_wr(3'd4, 8'd2); bus_wr(3'd5, 8'd1);
    run("stop", 1, 3, 2, 3, 2 + 2 * row_len(3, 2) + 3 + 1 + 3,
        3'd6, 8'd0, 1'b1, bn);
    chk_rd("stop_status", 3'd2, 8'h00);
    chk_rd("stop_frames", 3'd7, 8'h00);
    run("restart", 1, 3, 2, 3, 32'h7fffffff, 3'd0, 8'd0, 1'b0, bn);
    chk_int("restart_busy", bn, (S == 1) ? 158 : 154);

    run("softrst", 1, 3, 2, 3, -1, 3'd0, 8'd0, 1'b1, bn);
    chk_rd("softrst_len", 3'd3, 8'd4);
    chk_rd("softrst_half", 3'd4, 8'd1);
    chk_rd("softrst_status", 3'd2, 8'h00);

    bus_wr(3'd3, 8'd1); bus_wr(3'd4, 8'd1); bus_wr(3'd5, 8'd0);
    frame = 2 + ROWS * row_len(1, 1);
    run("cont", 3, 1, 1, 1, 2 * frame + 5, 3'd6, 8'd0, 1'b1, bn);
    chk_rd("cont_frames", 3'd7, 8'd2);
    chk_rd("cont_status", 3'd2, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
